tile_query_ctrl: RTL
====================

Name: tile_query_ctrl

Overview:
- Initiator side of the neighbour-check handshake: takes a candidate board cell (row, col) and fetches the cell and its four neighbours from the board RAM.
- Drives chk_start with the neighbour codes, waits for chk_end, and returns the legal-tile mask to the move generator / forced-move engine.
- Sits between the board RAM read port and the combinational/sequential tile checker.

Parameters:
ROWS, 8, board rows
COLS, 8, board columns
ROW_W, 3, row index width
COL_W, 3, column index width
ADDR_W, 6, board RAM address width (clog2(ROWS*COLS))
TIMEOUT, 16, max cycles to wait for chk_end after chk_start

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  query request
req_ready  out  1  high in IDLE only
req_row  in  ROW_W  candidate row (0 = top)
req_col  in  COL_W  candidate column (0 = left)
mem_rd_en  out  1  board RAM read strobe
mem_rd_addr  out  ADDR_W  row*COLS+col
mem_rd_data  in  3  tile code, valid the cycle after mem_rd_en
chk_start  out  1  one-cycle pulse to checker
chk_up, chk_down, chk_right, chk_left  out  3 each  neighbour codes, stable from chk_start until response
chk_tile_type  in  6  checker mask, bit i = code i+1 legal
chk_end  in  1  checker done
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_mask  out  6  legal tile mask
resp_forced  out  1  resp_mask has exactly one bit set
resp_error  out  1  cell occupied, bad code, or timeout

Behaviour:
- Tile codes: 0 empty, 1 slash_down, 2 slash_up, 3 plus_vrt, 4 plus_hz, 5 backslash_up, 6 backslash_down, 7 illegal.
- Reset (async, any state): FSM to IDLE; all outputs 0 except req_ready=1; neighbour regs, timeout counter, mask cleared.
- Request handshake: IDLE accepts on req_valid&&req_ready; row/col latched.
- FETCH (5 cycles, k=0..4): issues reads in order centre, up, down, right, left.
- Read data: captured into slot k-1 each cycle; LAST captures slot 4 (1 cycle).
- Off-board neighbours: row 0 up, row ROWS-1 down, col COLS-1 right, col 0 left. No read is issued (mem_rd_en=0 that cycle); the slot is forced to 0.
- After LAST, priority order:
  - Centre != 0, or any code == 7: go to RESP with mask 0, error 1.
  - All four neighbours 0: go to RESP with mask 6'b111111, no checker call.
  - Otherwise: go to START.
- START: chk_start=1 for exactly one cycle; timeout counter cleared.
- WAIT: from the START cycle onward, the first cycle with chk_end=1 latches chk_tile_type into resp_mask and goes to RESP.
  - Counter increments per cycle without chk_end.
  - At count == TIMEOUT, go to RESP with mask 0, error 1.
  - chk_end while not in START/WAIT is ignored.
- RESP: resp_valid=1. resp_mask, resp_forced and resp_error stay stable until resp_ready; the handshake cycle returns to IDLE.
  - resp_forced = popcount(mask)==1.
  - Mask 0 with no error (checker found no legal tile) sets resp_error=1.
- Latency, all-neighbour path with chk_end same cycle as chk_start: accept cycle 0, FETCH 1-5, LAST 6, START 7, resp_valid at cycle 8.
- Back-to-back: req_ready is low outside IDLE; the next request is accepted the cycle after the resp handshake.

Decomposition:
- Shared package trax_pkg: tile code constants (EMPTY..BACKSLASH_DOWN, ILLEGAL), mask bit indices, FSM state enum.
- The tile checker also uses trax_pkg.
- One natural sub-module: tile_nbr_addr, combinational. Maps (row, col, k) to {rd_en, addr}, with off-board suppression.

Test Plan:
- Request (3,3); RAM has up=1, all others 0 -> reads at addrs 27,19,35,28,26; chk_up=1; checker returns 6'b101010 with chk_end on START cycle -> resp_mask=101010, forced=0, error=0, resp_valid at cycle 8.
- Request (0,0), only right neighbour (0,1)=4 -> no reads for up/left; chk_up=chk_left=0; checker mask 6'b001000 -> forced=1.
- Request (2,2) with centre code 3 -> no chk_start; resp_mask=0, error=1. Same stimulus with a neighbour code 7 -> same response.
- Isolated cell, all neighbours empty -> no chk_start; mask=111111, forced=0, error=0.
- Checker never asserts chk_end, TIMEOUT=16 -> resp_valid 16 cycles after START, mask=0, error=1. A late chk_end afterwards is ignored.
- Hold resp_ready=0 for 10 cycles, then pulse -> outputs stable throughout. Next request then back-to-back. reset_n low mid-WAIT -> outputs 0 and req_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/trax_pkg.sv
// Shared tile-code, mask and FSM definitions for the trax move-query datapath.
// Used by the query controller, its address helper and the tile checker.
package trax_pkg;

  localparam logic [2:0] EMPTY          = 3'd0;
  localparam logic [2:0] SLASH_DOWN     = 3'd1;
  localparam logic [2:0] SLASH_UP       = 3'd2;
  localparam logic [2:0] PLUS_VRT       = 3'd3;
  localparam logic [2:0] PLUS_HZ        = 3'd4;
  localparam logic [2:0] BACKSLASH_UP   = 3'd5;
  localparam logic [2:0] BACKSLASH_DOWN = 3'd6;
  localparam logic [2:0] ILLEGAL        = 3'd7;

  // Mask bit i means tile code i+1 is legal.
  localparam int MASK_W            = 6;
  localparam int MB_SLASH_DOWN     = 0;
  localparam int MB_SLASH_UP       = 1;
  localparam int MB_PLUS_VRT       = 2;
  localparam int MB_PLUS_HZ        = 3;
  localparam int MB_BACKSLASH_UP   = 4;
  localparam int MB_BACKSLASH_DOWN = 5;
  localparam logic [MASK_W-1:0] MASK_ALL = 6'b111111;

  localparam logic [2:0] K_CENTRE = 3'd0;
  localparam logic [2:0] K_UP     = 3'd1;
  localparam logic [2:0] K_DOWN   = 3'd2;
  localparam logic [2:0] K_RIGHT  = 3'd3;
  localparam logic [2:0] K_LEFT   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LAST  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  function automatic logic is_onehot(input logic [MASK_W-1:0] m);
    int n;
    n = 0;
    for (int i = 0; i < MASK_W; i++) n += int'(m[i]);
    return (n == 1);
  endfunction

endpackage

// File: rtl/tile_nbr_addr.sv
// Maps (row, col, fetch index k) to a board RAM read; reads that would fall
// off the board edge are suppressed (rd_en=0, addr=0).
module tile_nbr_addr import trax_pkg::*; #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int ROW_W  = 3,
  parameter int COL_W  = 3,
  parameter int ADDR_W = 6
) (
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic [2:0]        k,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr
);

  logic [ROW_W-1:0] r;
  logic [COL_W-1:0] c;

  always_comb begin
    rd_en = 1'b1;
    r     = row;
    c     = col;
    case (k)
      K_CENTRE: ;
      K_UP: begin
        if (row == '0) rd_en = 1'b0;
        else           r = row - ROW_W'(1);
      end
      K_DOWN: begin
        if (row == ROW_W'(ROWS-1)) rd_en = 1'b0;
        else                       r = row + ROW_W'(1);
      end
      K_RIGHT: begin
        if (col == COL_W'(COLS-1)) rd_en = 1'b0;
        else                       c = col + COL_W'(1);
      end
      K_LEFT: begin
        if (col == '0) rd_en = 1'b0;
        else           c = col - COL_W'(1);
      end
      default: rd_en = 1'b0;
    endcase
    addr = rd_en ? (ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c)) : '0;
  end

endmodule

// File: rtl/tile_query_ctrl.sv
// Fetches a candidate cell plus its four neighbours from board RAM, runs the
// tile checker handshake and returns the legal-tile mask to the move engines.
module tile_query_ctrl import trax_pkg::*; #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int ROW_W   = 3,
  parameter int COL_W   = 3,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [COL_W-1:0]  req_col,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [2:0]        mem_rd_data,
  output logic              chk_start,
  output logic [2:0]        chk_up,
  output logic [2:0]        chk_down,
  output logic [2:0]        chk_right,
  output logic [2:0]        chk_left,
  input  logic [5:0]        chk_tile_type,
  input  logic              chk_end,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [5:0]        resp_mask,
  output logic              resp_forced,
  output logic              resp_error,
  output state_e            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // sender holds valid and payload stable until then (resp side: mask/forced/error).
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [2:0]        k_q, k_d;
  logic              prev_en_q, prev_en_d;
  logic [4:0][2:0]   nbr_q, nbr_d, nbr_cap;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        mask_q, mask_d;
  logic              err_q, err_d;
  logic              addr_en;
  logic [ADDR_W-1:0] addr_raw;
  logic [2:0]        cap_val;
  logic              any_illegal, all_empty;

  tile_nbr_addr #(
    .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W)
  ) u_nbr_addr (
    .row(row_q), .col(col_q), .k(k_q), .rd_en(addr_en), .addr(addr_raw)
  );

  // A slot whose read was suppressed (off-board) captures EMPTY.
  assign cap_val = prev_en_q ? mem_rd_data : EMPTY;

  always_comb begin
    nbr_cap = nbr_q;
    if ((state_q == ST_FETCH && k_q != K_CENTRE) || state_q == ST_LAST)
      nbr_cap[k_q - 3'd1] = cap_val;
    any_illegal = 1'b0;
    for (int i = 0; i < 5; i++) if (nbr_cap[i] == ILLEGAL) any_illegal = 1'b1;
    all_empty = (nbr_cap[K_UP] == EMPTY) && (nbr_cap[K_DOWN] == EMPTY) &&
                (nbr_cap[K_RIGHT] == EMPTY) && (nbr_cap[K_LEFT] == EMPTY);
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    k_d         = k_q;
    prev_en_d   = 1'b0;
    nbr_d       = nbr_cap;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    err_d       = err_q;
    req_ready   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    chk_start   = 1'b0;
    resp_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          row_d   = req_row;
          col_d   = req_col;
          k_d     = K_CENTRE;
          nbr_d   = '0;
          mask_d  = '0;
          err_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_rd_en   = addr_en;
        mem_rd_addr = addr_raw;
        prev_en_d   = addr_en;
        k_d         = k_q + 3'd1;
        if (k_q == K_LEFT) state_d = ST_LAST;
      end
      ST_LAST: begin
        if (nbr_cap[K_CENTRE] != EMPTY || any_illegal) begin
          mask_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (all_empty) begin
          mask_d  = MASK_ALL;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        chk_start = 1'b1;
        cnt_d     = '0;
        if (chk_end) begin
          mask_d  = chk_tile_type;
          err_d   = (chk_tile_type == '0);
          state_d = ST_RESP;
        end else begin
          // The START cycle itself counts toward the timeout window.
          cnt_d   = CNT_W'(1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (chk_end) begin
          mask_d  = chk_tile_type;
          err_d   = (chk_tile_type == '0);
          state_d = ST_RESP;
        end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
          mask_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      k_q       <= '0;
      prev_en_q <= 1'b0;
      nbr_q     <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      k_q       <= k_d;
      prev_en_q <= prev_en_d;
      nbr_q     <= nbr_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
    end
  end

  assign chk_up      = nbr_q[K_UP];
  assign chk_down    = nbr_q[K_DOWN];
  assign chk_right   = nbr_q[K_RIGHT];
  assign chk_left    = nbr_q[K_LEFT];
  assign resp_mask   = (state_q == ST_RESP) ? mask_q : '0;
  assign resp_error  = (state_q == ST_RESP) ? err_q : 1'b0;
  assign resp_forced = (state_q == ST_RESP) ? is_onehot(mask_q) : 1'b0;
  assign dbg_state   = state_q;

endmodule
